// File: rtl/compressed_encoder_pkg.sv
// Shared definitions for the RV32 -> RVC encoder: base opcodes, special
// encodings, packer state and an immediate range helper.
package compressed_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [15:0] C_NOP    = 16'h0001;
  localparam logic [31:0] EBREAK   = 32'h00100073;
  localparam logic [15:0] C_EBREAK = 16'h9002;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;

  typedef enum logic {
    PK_EMPTY = 1'b0,
    PK_HALF  = 1'b1
  } pk_state_e;

  // Signed inclusive range test on a sign-extended immediate.
  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/compressed_encoder_if.sv
// Instruction-in / packed-word-out streams of the RVC encoder, plus the
// packer state exposed for observation.
interface compressed_encoder_if;

  // A beat moves on a rising clk edge where valid & ready are both high;
  // valid never waits on ready, and payload holds while valid & ~ready.
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        out_pad_o;
  compressed_encoder_pkg::pk_state_e pk_state_o;

  modport master (
    output in_valid_i, in_instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_pad_o, pk_state_o
  );

  modport slave (
    input  in_valid_i, in_instr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_pad_o, pk_state_o
  );

endinterface

// File: rtl/compressed_encoder_c_compress.sv
// Combinational RV32 -> RVC mapping: yields the 16-bit parcel and is_c when
// the instruction has an exact compressed equivalent.
module c_compress
  import compressed_encoder_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_c_o,
  output logic [15:0] parcel_o
);

  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic        rd_p, rs1_p, rs2_p;
  logic [1:0]  alu_sel;

  assign opc   = instr_i[6:0];
  assign rd    = instr_i[11:7];
  assign f3    = instr_i[14:12];
  assign rs1   = instr_i[19:15];
  assign rs2   = instr_i[24:20];
  assign f7    = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign rd_p  = (rd[4:3] == 2'b01);
  assign rs1_p = (rs1[4:3] == 2'b01);
  assign rs2_p = (rs2[4:3] == 2'b01);

  always_comb begin
    is_c_o   = 1'b0;
    parcel_o = 16'h0000;
    alu_sel  = 2'b00;
    if (instr_i == EBREAK) begin
      is_c_o   = 1'b1;
      parcel_o = C_EBREAK;
    end else begin
      case (opc)
        OPC_OP_IMM: begin
          if (f3 == 3'b000) begin
            // addi16sp claims the x2,x2 form before the generic c.addi
            if (rd == 5'd2 && rs1 == 5'd2 && imm_i != '0 && imm_i[3:0] == 4'd0 &&
                in_range(imm_i, -512, 496)) begin
              is_c_o   = 1'b1;
              parcel_o = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
            end else if (rd != 5'd0 && rd == rs1 && imm_i != '0 && in_range(imm_i, -32, 31)) begin
              is_c_o   = 1'b1;
              parcel_o = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            end else if (rd_p && rs1 == 5'd2 && imm_i[1:0] == 2'd0 && in_range(imm_i, 4, 1020)) begin
              is_c_o   = 1'b1;
              parcel_o = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
            end else if (rd != 5'd0 && rs1 == 5'd0 && in_range(imm_i, -32, 31)) begin
              is_c_o   = 1'b1;
              parcel_o = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            end
          end else if (f3 == 3'b001 && f7 == 7'd0 && rd != 5'd0 && rd == rs1 && rs2 != 5'd0) begin
            is_c_o   = 1'b1;
            parcel_o = {3'b000, 1'b0, rd, rs2, 2'b10};
          end else if (f3 == 3'b101 && rd_p && rd == rs1 && rs2 != 5'd0 &&
                       (f7 == 7'd0 || f7 == F7_ALT)) begin
            is_c_o   = 1'b1;
            parcel_o = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
          end else if (f3 == 3'b111 && rd_p && rd == rs1 && in_range(imm_i, -32, 31)) begin
            is_c_o   = 1'b1;
            parcel_o = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
          end
        end
        OPC_LUI: begin
          if (rd != 5'd0 && rd != 5'd2 && instr_i[17:12] != 6'd0 &&
              instr_i[31:17] == {15{instr_i[17]}}) begin
            is_c_o   = 1'b1;
            parcel_o = {3'b011, instr_i[17], rd, instr_i[16:12], 2'b01};
          end
        end
        OPC_OP: begin
          case ({f7, f3})
            {F7_ALT, 3'b000}: alu_sel = 2'b00;
            {7'd0, 3'b100}:   alu_sel = 2'b01;
            {7'd0, 3'b110}:   alu_sel = 2'b10;
            {7'd0, 3'b111}:   alu_sel = 2'b11;
            default:          alu_sel = 2'b00;
          endcase
          if (rd_p && rd == rs1 && rs2_p &&
              ({f7, f3} == {F7_ALT, 3'b000} || (f7 == 7'd0 && f3[2]))) begin
            is_c_o   = (f3 != 3'b101);
            parcel_o = {6'b100011, rd[2:0], alu_sel, rs2[2:0], 2'b01};
          end else if (f7 == 7'd0 && f3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0 &&
                       (rs1 == 5'd0 || rs1 == rd)) begin
            is_c_o   = 1'b1;
            parcel_o = {3'b100, (rs1 != 5'd0), rd, rs2, 2'b10};
          end
        end
        OPC_LOAD: begin
          if (f3 == 3'b010 && imm_i[1:0] == 2'd0) begin
            if (rd_p && rs1_p && in_range(imm_i, 0, 124)) begin
              is_c_o   = 1'b1;
              parcel_o = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
            end else if (rs1 == 5'd2 && rd != 5'd0 && in_range(imm_i, 0, 252)) begin
              is_c_o   = 1'b1;
              parcel_o = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
            end
          end
        end
        OPC_STORE: begin
          if (f3 == 3'b010 && imm_s[1:0] == 2'd0) begin
            if (rs1_p && rs2_p && in_range(imm_s, 0, 124)) begin
              is_c_o   = 1'b1;
              parcel_o = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
            end else if (rs1 == 5'd2 && in_range(imm_s, 0, 252)) begin
              is_c_o   = 1'b1;
              parcel_o = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
            end
          end
        end
        OPC_JAL: begin
          if (rd[4:1] == 4'd0 && in_range(imm_j, -2048, 2046)) begin
            is_c_o   = 1'b1;
            parcel_o = {~rd[0], 2'b01, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10], imm_j[6],
                        imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
          end
        end
        OPC_JALR: begin
          if (f3 == 3'b000 && imm_i == '0 && rs1 != 5'd0 && rd[4:1] == 4'd0) begin
            is_c_o   = 1'b1;
            parcel_o = {3'b100, rd[0], rs1, 5'd0, 2'b10};
          end
        end
        OPC_BRANCH: begin
          if (f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_p && in_range(imm_b, -256, 254)) begin
            is_c_o   = 1'b1;
            parcel_o = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6], imm_b[2:1],
                        imm_b[5], 2'b01};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/compressed_encoder.sv
// Streaming RV32 -> RVC encoder: compresses each instruction and packs 16/32-bit
// parcels into little-endian words. Optional counters: COMPRESSED_ENCODER_STATS_EN.
module compressed_encoder
  import compressed_encoder_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  compressed_encoder_if.slave        bus,
  output logic                       illegal_o,
  output logic [31:0]                cnt_in_o,
  output logic [31:0]                cnt_comp_o
);

  pk_state_e   state_q;
  logic [15:0] pend_q;
  logic        out_valid_q, out_pad_q, illegal_q;
  logic [31:0] out_data_q;
  logic        slot_free, accept, legal, is_c;
  logic [15:0] parcel;

  c_compress u_c_compress (
    .instr_i  (bus.in_instr_i),
    .is_c_o   (is_c),
    .parcel_o (parcel)
  );

  assign slot_free      = ~out_valid_q | bus.out_ready_i;
  assign bus.in_ready_o = slot_free & ~flush_i;
  assign accept         = bus.in_valid_i & bus.in_ready_o;
  assign legal          = (bus.in_instr_i[1:0] == 2'b11);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PK_EMPTY;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pad_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= accept & ~legal;
      if (slot_free) out_valid_q <= 1'b0;
      // Flush blocks input acceptance, so it cannot collide with a new parcel.
      if (flush_i && slot_free) begin
        if (state_q == PK_HALF) begin
          out_valid_q <= 1'b1;
          out_data_q  <= {C_NOP, pend_q};
          out_pad_q   <= 1'b1;
          state_q     <= PK_EMPTY;
        end
      end else if (accept && legal) begin
        if (state_q == PK_EMPTY) begin
          if (is_c) begin
            pend_q  <= parcel;
            state_q <= PK_HALF;
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_instr_i;
            out_pad_q   <= 1'b0;
          end
        end else begin
          out_valid_q <= 1'b1;
          out_pad_q   <= 1'b0;
          if (is_c) begin
            out_data_q <= {parcel, pend_q};
            state_q    <= PK_EMPTY;
          end else begin
            out_data_q <= {bus.in_instr_i[15:0], pend_q};
            pend_q     <= bus.in_instr_i[31:16];
          end
        end
      end
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_pad_o   = out_pad_q;
  assign bus.pk_state_o  = state_q;
  assign illegal_o       = illegal_q;

`ifdef COMPRESSED_ENCODER_STATS_EN
  logic [31:0] cnt_in_q, cnt_comp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_in_q   <= '0;
      cnt_comp_q <= '0;
    end else if (accept && legal) begin
      cnt_in_q <= cnt_in_q + 32'd1;
      if (is_c) cnt_comp_q <= cnt_comp_q + 32'd1;
    end
  end

  assign cnt_in_o   = cnt_in_q;
  assign cnt_comp_o = cnt_comp_q;
`else
  assign cnt_in_o   = 32'd0;
  assign cnt_comp_o = 32'd0;
`endif

endmodule
